// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI4-Lite definitions: response codes and the
//               master FSM state encoding.
// Contents    : RESP_* response constants, mst_state_e (3-bit state enum)
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } mst_state_e;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_wdog.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_wdog
// Description : Response watchdog. Loadable down-counter; o_expired is high
//               while enabled and the counter has run down to zero, i.e.
//               during the TIMEOUT-th enabled cycle after a load.
//               TIMEOUT = 0 removes the counter and never expires.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_load        - reload to TIMEOUT-1 (restart the wait)
//               i_en          - count this cycle
//               o_expired     - wait budget exhausted
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  if (TIMEOUT == 0) begin : g_wdog_off
    logic w_unused;
    assign w_unused  = &{1'b0, clk, rst, i_load, i_en};
    assign o_expired = 1'b0;
  end else begin : g_wdog_on
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
        cnt_d = C_LOAD;
      end else if (i_en && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= C_LOAD;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // A reload in the same cycle means the wait restarted; do not fire.
    assign o_expired = i_en & ~i_load & (cnt_q == '0);
  end

endmodule : axi_lite_wdog
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master
// Description : AXI4-Lite initiator. Converts single-beat commands into
//               AXI4-Lite reads/writes, one transaction outstanding, with a
//               response watchdog that aborts on a hung slave.
// Ports       : aclk, areset            - clock, synchronous active-high reset
//               cmd_*                   - command in (valid/ready handshake)
//               rsp_*                   - response out (valid/ready handshake)
//               m_axi_*                 - AXI4-Lite master channels
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  // response
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  // AXI write address
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI write response
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  mst_state_e          state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                timeout_q, timeout_d;
  // Set after an abort: the slave still owes one B (or R). The first such
  // beat seen in a later WR_B (RD_R) is consumed and discarded.
  logic                orphan_b_q, orphan_b_d;
  logic                orphan_r_q, orphan_r_d;

  logic w_cmd_fire, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
  logic w_waiting, w_discard, w_expired;

  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_w_fire   = m_axi_wvalid & m_axi_wready;
  assign w_b_fire   = m_axi_bvalid & m_axi_bready;
  assign w_ar_fire  = m_axi_arvalid & m_axi_arready;
  assign w_r_fire   = m_axi_rvalid & m_axi_rready;
  assign w_waiting  = (state_q == ST_WR_B) | (state_q == ST_RD_R);
  assign w_discard  = (w_b_fire & orphan_b_q) | (w_r_fire & orphan_r_q);

  // Reloaded outside the response-wait states, so it restarts on entry.
  axi_lite_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (aclk),
    .rst       (areset),
    .i_load    (~w_waiting | w_discard),
    .i_en      (w_waiting),
    .o_expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= RESP_OKAY;
      timeout_q  <= 1'b0;
      orphan_b_q <= 1'b0;
      orphan_r_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
      orphan_b_q <= orphan_b_d;
      orphan_r_q <= orphan_r_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_cmd_fire) state_d = cmd_write ? ST_WR_AW_W : ST_RD_AR;
      end
      ST_WR_AW_W: begin
        // AW and W complete independently, possibly in the same cycle.
        if ((aw_done_q | w_aw_fire) & (w_done_q | w_w_fire)) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        if (w_b_fire) begin
          if (!orphan_b_q) state_d = ST_RSP;
        end else if (w_expired) begin
          state_d = ST_RSP;
        end
      end
      ST_RD_AR: begin
        if (w_ar_fire) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        if (w_r_fire) begin
          if (!orphan_r_q) state_d = ST_RSP;
        end else if (w_expired) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch, handshake flags and response capture
  // --------------------------------------------------------------------------
  always_comb begin
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    orphan_b_d = orphan_b_q;
    orphan_r_d = orphan_r_q;

    if (w_cmd_fire) begin
      addr_d    = cmd_addr;
      wdata_d   = cmd_wdata;
      wstrb_d   = cmd_wstrb;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end

    if (state_q == ST_WR_AW_W) begin
      if (w_aw_fire) aw_done_d = 1'b1;
      if (w_w_fire)  w_done_d  = 1'b1;
    end

    if (state_q == ST_WR_B) begin
      if (w_b_fire) begin
        if (orphan_b_q) begin
          orphan_b_d = 1'b0;
        end else begin
          rdata_d   = '0;
          resp_d    = m_axi_bresp;
          timeout_d = 1'b0;
        end
      end else if (w_expired) begin
        rdata_d    = '0;
        resp_d     = RESP_SLVERR;
        timeout_d  = 1'b1;
        orphan_b_d = 1'b1;
      end
    end

    if (state_q == ST_RD_R) begin
      if (w_r_fire) begin
        if (orphan_r_q) begin
          orphan_r_d = 1'b0;
        end else begin
          rdata_d   = m_axi_rdata;
          resp_d    = m_axi_rresp;
          timeout_d = 1'b0;
        end
      end else if (w_expired) begin
        rdata_d    = '0;
        resp_d     = RESP_SLVERR;
        timeout_d  = 1'b1;
        orphan_r_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready     = (state_q == ST_IDLE) & ~areset;
    m_axi_awvalid = (state_q == ST_WR_AW_W) & ~aw_done_q;
    m_axi_wvalid  = (state_q == ST_WR_AW_W) & ~w_done_q;
    m_axi_bready  = (state_q == ST_WR_B);
    m_axi_arvalid = (state_q == ST_RD_AR);
    m_axi_rready  = (state_q == ST_RD_R);
    rsp_valid     = (state_q == ST_RSP);
    m_axi_awaddr  = addr_q;
    m_axi_araddr  = addr_q;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = wstrb_q;
    m_axi_awprot  = 3'b000;
    m_axi_arprot  = 3'b000;
    rsp_rdata     = rdata_q;
    rsp_resp      = resp_q;
    rsp_timeout   = timeout_q;
  end

endmodule : axi_lite_master
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master
// Description : Self-checking bench for axi_lite_master with a small
//               configurable AXI4-Lite slave model and a protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- slave model ----------------
  int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic        cfg_r_never;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_resp;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int          n_aw, n_w, n_b, n_ar, n_r;
  logic        aw_hs, w_hs, ar_hs;

  assign awready = awvalid && (aw_cnt >= cfg_aw_dly);
  assign wready  = wvalid  && (w_cnt  >= cfg_w_dly);
  assign arready = arvalid && (ar_cnt >= cfg_ar_dly);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  always @(posedge aclk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
    end else begin
      if (awvalid) begin
        if (aw_hs) begin aw_got <= 1'b1; aw_cnt <= 0; s_awaddr <= awaddr; n_aw <= n_aw + 1; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid) begin
        if (w_hs) begin w_got <= 1'b1; w_cnt <= 0; s_wdata <= wdata; s_wstrb <= wstrb; n_w <= n_w + 1; end
        else w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; n_b <= n_b + 1;
      end else if (!bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
        if (b_cnt >= cfg_b_dly) begin
          bvalid <= 1'b1; bresp <= cfg_resp; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (arvalid) begin
        if (ar_hs) begin ar_got <= 1'b1; ar_cnt <= 0; s_araddr <= araddr; n_ar <= n_ar + 1; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; n_r <= n_r + 1;
      end else if (!rvalid && (ar_got || ar_hs) && !cfg_r_never) begin
        if (r_cnt >= cfg_r_dly) begin
          rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_resp; ar_got <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  // A valid must stay up (with stable payload) until its handshake, and must
  // drop right after it because only one transaction is in flight.
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  int          viol, rready_cnt;

  always @(negedge aclk) begin
    if (!areset && !p_rst) begin
      if ((p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) || (p_awv && p_awr && awvalid) ||
          (p_wv  && !p_wr  && (!wvalid  || wdata  != p_wdata))  || (p_wv  && p_wr  && wvalid)  ||
          (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) || (p_arv && p_arr && arvalid))
        viol <= viol + 1;
    end
    if (rready) rready_cnt <= rready_cnt + 1;
    p_rst <= areset;
    p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
    p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
    p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge. Returns at the first negedge after the accept edge.
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int guard;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge aclk); guard++; end
    chk("cmd_accept", {31'b0, cmd_ready}, 32'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  // lat = negedge index after accept at which rsp_valid is first seen high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge aclk); lat++; end
    chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic set_slave(input int awd, input int wd, input int bd, input int ard, input int rd,
                           input logic [31:0] rdat, input logic [1:0] resp);
    cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
    cfg_rdata = rdat; cfg_resp = resp; cfg_r_never = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    int          e_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int lat, b0, aw0, w0, r0, ar0, v0, rr0;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_resp;

    vecs[0] = '{1'b1, 32'h04, 32'h1,        4'hF, 0, 0, 0, 0, 0, 32'h0,        RESP_OKAY,   32'h0,        RESP_OKAY,   3};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 4, 32'd168,      RESP_OKAY,   32'd168,      RESP_OKAY,   7};
    vecs[2] = '{1'b1, 32'h14, 32'hCAFE0001, 4'hF, 3, 0, 0, 0, 0, 32'h0,        RESP_OKAY,   32'h0,        RESP_OKAY,   6};
    vecs[3] = '{1'b1, 32'h18, 32'hCAFE0002, 4'h5, 0, 3, 0, 0, 0, 32'h0,        RESP_OKAY,   32'h0,        RESP_OKAY,   6};
    vecs[4] = '{1'b1, 32'h1C, 32'h00BADBAD, 4'hC, 0, 0, 2, 0, 0, 32'h0,        RESP_SLVERR, 32'h0,        RESP_SLVERR, 5};
    vecs[5] = '{1'b0, 32'h2C, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, RESP_DECERR, 32'hDEADBEEF, RESP_DECERR, 3};
    vecs[6] = '{1'b0, 32'h3C, 32'h0,        4'h0, 0, 0, 0, 2, 1, 32'h12345678, RESP_OKAY,   32'h12345678, RESP_OKAY,   6};

    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    set_slave(0, 0, 0, 0, 0, 32'h0, RESP_OKAY);
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; viol = 0; rready_cnt = 0;

    // ---- reset state ----
    repeat (3) @(negedge aclk);
    chk("rst_valids", {26'b0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    chk("rst_cmd_ready_in_reset", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_fields", {29'b0, rsp_timeout, rsp_resp}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_prot", {26'b0, awprot, arprot}, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // ---- table-driven transactions ----
    for (int i = 0; i < 7; i++) begin
      set_slave(vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].ar_dly, vecs[i].r_dly,
                vecs[i].s_rdata, vecs[i].s_resp);
      b0 = n_b; aw0 = n_aw; w0 = n_w; r0 = n_r; ar0 = n_ar; v0 = viol;
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdat, vecs[i].strb);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_resp", i), {30'b0, rsp_resp}, {30'b0, vecs[i].e_resp});
      chk($sformatf("v%0d_timeout", i), {31'b0, rsp_timeout}, 32'd0);
      ack_rsp();
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_awaddr", i), s_awaddr, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), s_wdata, vecs[i].wdat);
        chk($sformatf("v%0d_wstrb", i), {28'b0, s_wstrb}, {28'b0, vecs[i].strb});
        chk($sformatf("v%0d_hs_counts", i), (n_aw - aw0) * 100 + (n_w - w0) * 10 + (n_b - b0), 32'd111);
      end else begin
        chk($sformatf("v%0d_araddr", i), s_araddr, vecs[i].addr);
        chk($sformatf("v%0d_hs_counts", i), (n_ar - ar0) * 10 + (n_r - r0), 32'd11);
      end
      chk($sformatf("v%0d_protocol", i), viol - v0, 32'd0);
      chk($sformatf("v%0d_idle_after", i), {31'b0, cmd_ready}, 32'd1);
    end

    // ---- response back-pressure: rsp_ready low for 10 cycles ----
    set_slave(0, 0, 0, 0, 0, 32'h0BEEF00D, RESP_EXOKAY);
    send_cmd(1'b1, 32'h08, 32'h0000A5A5, 4'h3);
    wait_rsp(lat);
    hold_rdata = rsp_rdata; hold_resp = rsp_resp;
    chk("stall_resp_value", {30'b0, hold_resp}, {30'b0, RESP_EXOKAY});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    ar0 = n_ar;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("stall_fields", {rsp_rdata[29:0], rsp_resp}, {hold_rdata[29:0], hold_resp});
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    chk("post_stall_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_stall_no_early_ar", n_ar - ar0, 32'd0);
    @(negedge aclk);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("post_stall_latency", lat, 32'd3);
    chk("post_stall_rdata", rsp_rdata, 32'h0BEEF00D);
    ack_rsp();

    // ---- watchdog abort: slave never returns R ----
    set_slave(0, 0, 0, 0, 0, 32'h0, RESP_OKAY);
    cfg_r_never = 1'b1;
    rr0 = rready_cnt;
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp(lat);
    chk("to_latency", lat, 32'd18);
    chk("to_flag", {31'b0, rsp_timeout}, 32'd1);
    chk("to_resp", {30'b0, rsp_resp}, {30'b0, RESP_SLVERR});
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_rready_low", {31'b0, rready}, 32'd0);
    ack_rsp();
    chk("to_rready_cycles", rready_cnt - rr0, TO);

    // late R after the abort must not be taken now nor count for the next read
    r0 = n_r;
    cfg_rdata = 32'h55; cfg_r_never = 1'b0;
    repeat (3) @(negedge aclk);
    chk("late_r_pending_not_taken", {30'b0, rvalid, rready}, 32'd2);
    cfg_rdata = 32'h77;
    send_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    wait_rsp(lat);
    chk("late_r_latency", lat, 32'd5);
    chk("late_r_rdata", rsp_rdata, 32'h77);
    chk("late_r_timeout", {31'b0, rsp_timeout}, 32'd0);
    ack_rsp();
    chk("late_r_beats", n_r - r0, 32'd2);

    // ---- reset in the middle of WR_AW_W ----
    set_slave(5, 5, 0, 0, 0, 32'h0, RESP_OKAY);
    b0 = n_b;
    send_cmd(1'b1, 32'h40, 32'h99, 4'hF);
    chk("mid_rst_in_aw_w", {30'b0, awvalid, wvalid}, 32'd3);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_valids", {26'b0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_rst_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_no_b", n_b - b0, 32'd0);
    set_slave(0, 0, 0, 0, 0, 32'h0, RESP_OKAY);
    send_cmd(1'b1, 32'h44, 32'h1234, 4'hF);
    wait_rsp(lat);
    chk("after_rst_latency", lat, 32'd3);
    ack_rsp();
    chk("after_rst_awaddr", s_awaddr, 32'h44);
    chk("after_rst_one_b", n_b - b0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_axi_lite_master
`default_nettype wire
